// File: rtl/block_s2p_4.sv
// ============================================================================
// Module      : block_s2p_4
// Description : Serial-to-parallel packer. Groups 4 samples per block into a
//               small block FIFO. Optional macro S2P_FLUSH_EN adds in_last to
//               close a short block early, zero-filling the remaining lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_s2p_4 #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
`ifdef S2P_FLUSH_EN
  input  logic              in_last,
`endif
  output logic              in_ready,
  output logic [DATA_W-1:0] out_x1,
  output logic [DATA_W-1:0] out_x2,
  output logic [DATA_W-1:0] out_x3,
  output logic [DATA_W-1:0] out_x4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        blk_count
);

  localparam int             AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int             BLK_W   = 4 * DATA_W;
  localparam logic [AW:0]    PTR_ONE = 1;

  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_slot [0:2];
  logic [BLK_W-1:0]  r_mem  [0:FIFO_DEPTH-1];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [7:0]        r_blk_count;

  logic              w_full;
  logic              w_empty;
  logic              w_close;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [BLK_W-1:0]  w_blk;
  logic [BLK_W-1:0]  w_head;

  // Extra MSB on the pointers separates full from empty when the indices match
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

`ifdef S2P_FLUSH_EN
  assign w_close = (r_cnt == 2'd3) || in_last;
`else
  assign w_close = (r_cnt == 2'd3);
`endif

  assign in_ready = !(w_close && w_full);
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_close;
  assign w_pop    = !w_empty && out_ready;

  // Lanes below cnt come from the slots, lane cnt is the live sample, the rest are zero
  always_comb begin
    w_blk = '0;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < r_cnt) begin
        w_blk[k*DATA_W +: DATA_W] = r_slot[k];
      end
    end
    w_blk[r_cnt*DATA_W +: DATA_W] = in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 2'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_blk_count <= 8'd0;
      for (int k = 0; k < 3; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        if (w_push) begin
          r_cnt    <= 2'd0;
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end else begin
          r_cnt <= r_cnt + 2'd1;
          for (int k = 0; k < 3; k++) begin
            if (r_cnt == 2'(k)) begin
              r_slot[k] <= in_data;
            end
          end
        end
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        r_blk_count <= r_blk_count + 8'd1;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_blk;
    end
  end

  assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign out_x1    = w_head[0*DATA_W +: DATA_W];
  assign out_x2    = w_head[1*DATA_W +: DATA_W];
  assign out_x3    = w_head[2*DATA_W +: DATA_W];
  assign out_x4    = w_head[3*DATA_W +: DATA_W];
  assign out_valid = !w_empty;
  assign blk_count = r_blk_count;

endmodule

`default_nettype wire

// File: tb/tb_block_s2p_4.sv
// ============================================================================
// Module      : tb_block_s2p_4
// Description : Self-checking bench for block_s2p_4 against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_s2p_4;

  localparam int DEPTH = 2;
`ifdef S2P_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] x1, x2, x3, x4;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  blk_count;

  int tests = 0;
  int fails = 0;

  // Reference model: samples waiting to form a block, and completed blocks
  logic [31:0]  part [$];
  logic [127:0] fifo [$];
  logic [7:0]   pops;

  block_s2p_4 #(.DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef S2P_FLUSH_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_x1    (x1),
    .out_x2    (x2),
    .out_x3    (x3),
    .out_x4    (x4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic last);
    logic close;
    close = (part.size() == 3) || (FLUSH && last);
    return !(close && fifo.size() == DEPTH);
  endfunction

  // Called at posedge+1: drive inputs, compare, advance the model, cross one edge
  task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                       input logic r, output logic acc);
    logic         er;
    logic [127:0] head;
    logic [127:0] b;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    er   = model_ready(l);
    head = (fifo.size() != 0) ? fifo[0] : 128'd0;
    check("in_ready",  {127'd0, in_ready},  {127'd0, er});
    check("out_valid", {127'd0, out_valid}, {127'd0, fifo.size() != 0});
    check("block",     {x4, x3, x2, x1},    head);
    check("blk_count", {120'd0, blk_count}, {120'd0, pops});
    acc = v && er;
    if (fifo.size() != 0 && r) begin
      void'(fifo.pop_front());
      pops = pops + 8'd1;
    end
    if (acc) begin
      part.push_back(d);
      if (part.size() == 4 || (FLUSH && l)) begin
        b = '0;
        for (int k = 0; k < part.size(); k++) b[k*32 +: 32] = part[k];
        fifo.push_back(b);
        part.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] d, input logic l, input logic r);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle(1'b1, d, l, r, acc);
      n++;
    end while (!acc && n < 20);
    check("feed_accept", {127'd0, acc}, 128'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    pops = 8'd0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {127'd0, out_valid}, 128'd0);
    check("rst_data",  {x4, x3, x2, x1},    128'd0);
    check("rst_count", {120'd0, blk_count}, 128'd0);
    rst = 1'b1;
    #1;
    check("rst_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) feed(32'(i), 1'b0, 1'b1);
    idle(2);
    check("stream_count", {120'd0, blk_count}, 128'd2);

    // Backpressure: two full blocks stored, fourth sample of third block stalls
    for (int i = 0; i < 11; i++) feed(32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'd11, 1'b0, 1'b0, acc);
    check("bp_stall", {127'd0, in_ready}, 128'd0);
    feed(32'd11, 1'b0, 1'b1);
    idle(4);

    // Signed extremes, push coinciding with a pop
    for (int i = 0; i < 4; i++) feed(32'(100 + i), 1'b0, 1'b0);
    feed(32'hFFFF_FFFF, 1'b0, 1'b0);
    feed(32'h8000_0000, 1'b0, 1'b0);
    feed(32'h7FFF_FFFF, 1'b0, 1'b0);
    feed(32'd5, 1'b0, 1'b1);
    check("signed_valid", {127'd0, out_valid}, 128'd1);
    check("signed_blk", {x4, x3, x2, x1},
          {32'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF});
    idle(2);

    // Reset after two samples of a block
    feed(32'd1, 1'b0, 1'b0);
    feed(32'd2, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_valid", {127'd0, out_valid}, 128'd0);
    check("midrst_data",  {x4, x3, x2, x1},    128'd0);
    part.delete(); fifo.delete(); pops = 8'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) feed(32'd9, 1'b0, 1'b0);
    check("midrst_blk", {x4, x3, x2, x1}, {32'd9, 32'd9, 32'd9, 32'd9});
    idle(2);

`ifdef S2P_FLUSH_EN
    feed(32'd7, 1'b0, 1'b0);
    feed(32'd8, 1'b1, 1'b0);
    check("flush_blk", {x4, x3, x2, x1}, {32'd0, 32'd0, 32'd8, 32'd7});
    idle(1);
    for (int i = 1; i <= 4; i++) feed(32'(i), 1'b0, 1'b0);
    check("flush_next", {x4, x3, x2, x1}, {32'd4, 32'd3, 32'd2, 32'd1});
    idle(2);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, $urandom, FLUSH && (($urandom % 5) == 0),
            ($urandom % 3) != 0, acc);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/block_s2p_4.md
Name: block_s2p_4

Overview:
- Upstream serial-to-parallel stage for top_B_x_B.
- Accepts a stream of signed 32-bit samples, one per cycle, over a valid/ready handshake.
- Packs every 4 consecutive samples into one block and presents it on four parallel outputs, which drive x1..x4 of the block-processing core.
- A 2-entry block FIFO decouples sample arrival from block consumption.

Parameters:
- DATA_W, 32, sample width in bits, two's complement.
- FIFO_DEPTH, 2, number of complete blocks buffered; power of 2, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- out_x1..out_x4  out  DATA_W each  block samples; out_x1 is the oldest sample.
- out_valid  out  1  a complete block is presented.
- out_ready  in  1  consumer takes the block this cycle.
- blk_count  out  8  blocks emitted since reset; wraps 255->0.

Behaviour:
- Reset (rst=0, asynchronous):
  - fill counter = 0, FIFO empty.
  - out_x1..out_x4 = 0, out_valid = 0, blk_count = 0.
  - in_ready = 1 once rst is released.
- Sample accept occurs when in_valid && in_ready on a rising edge:
  - the sample is written to assembly slot[cnt];
  - cnt increments (0->1->2->3).
- Block push: when a sample is accepted with cnt==3:
  - slots 0..2 plus the current sample form one block, written to the FIFO tail;
  - cnt returns to 0.
- in_ready = (cnt != 3) || !fifo_full. in_ready must not depend combinationally on out_ready.
- Output side:
  - out_valid = !fifo_empty.
  - out_x1..out_x4 show the FIFO head entry and are driven 0 while the FIFO is empty.
- Block pop: when out_valid && out_ready, the head advances and blk_count increments.
- Latency: the 4th sample of a block, accepted at edge N, makes out_valid=1 immediately after edge N when the FIFO was empty.
- Simultaneous push and pop in one cycle: both take effect and occupancy is unchanged. With FIFO full and cnt==3, in_ready stays 0 even if a pop happens that cycle.
- Data integrity: samples pass bit-exact. No arithmetic and no sign change. Order is preserved within a block and across blocks.
- Empty FIFO with out_ready=1: no effect.
- Partial block held in the assembly register: never emitted (except under the optional feature below).
- Reset mid-block: the partial block and all FIFO contents are discarded, with no output glitch beyond outputs going to 0.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

Optional Feature:
- Macro: S2P_FLUSH_EN.
- When defined:
  - adds input port in_last (1 bit), sampled together with accepted samples.
  - A sample accepted with in_last=1 and cnt<3 closes the block immediately. Remaining slots are zero-filled and the block is pushed; this needs !fifo_full, otherwise in_ready=0.
  - in_last=1 with cnt==3 behaves as a normal push.
- When undefined: no in_last port; blocks are only ever completed by 4 samples.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> out_valid=0, out_x1..out_x4=0, blk_count=0; in_ready=1 after release.
- Streaming: feed samples 0..7 back-to-back with out_ready=1 -> block (0,1,2,3) valid right after the 4th accept edge, then block (4,5,6,7); blk_count=2.
- Backpressure: out_ready=0, feed 12 samples -> blocks (0..3) and (4..7) stored; in_ready falls when cnt==3 with the FIFO full, so sample 11 stalls. Raising out_ready releases both blocks in order, then block (8..11).
- Signedness and simultaneous events: feed -1, -2147483648, 2147483647, 5 while a pop occurs on the same edge as the push -> exact values on out_x1..out_x4 and FIFO occupancy unchanged.
- Reset mid-block: after 2 accepted samples, pulse rst -> the next 4 samples 9,9,9,9 produce block (9,9,9,9) with no stale data.
- S2P_FLUSH_EN defined: feed 7, 8 with in_last on 8 -> block (7,8,0,0) emitted; the next block starts at slot 0.
